// File: rtl/bus_mux_pipe.sv
// rtl/bus_mux_pipe.sv - registered priority bus multiplexer with conflict detection and counting
module bus_mux_pipe #(
  parameter int DATA_W    = 32,
  parameter int NUM_SRC   = 24,
  parameter int SEL_W     = 5,
  parameter bit HOLD_IDLE = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_en,
  input  logic                      cnt_clear,
  output logic [DATA_W-1:0]         bus_out,
  output logic                      bus_valid,
  output logic [SEL_W-1:0]          bus_sel,
  output logic                      conflict,
  output logic [CNT_W-1:0]          conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [SEL_W-1:0]  win;
  logic [DATA_W-1:0] win_data;
  logic              any;
  logic              multi;

  // Lowest enabled index wins; any later enable marks a multi-driver cycle
  always_comb begin
    win      = '0;
    win_data = '0;
    any      = 1'b0;
    multi    = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_en[i]) begin
        if (any) begin
          multi = 1'b1;
        end else begin
          win      = SEL_W'(i);
          win_data = src_data[i*DATA_W +: DATA_W];
        end
        any = 1'b1;
      end
    end
  end

  // Bus register: winner is driven even during a conflict; idle either holds or zeroes
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      bus_out   <= '0;
      bus_sel   <= '0;
      bus_valid <= 1'b0;
      conflict  <= 1'b0;
    end else begin
      if (any) begin
        bus_out <= win_data;
        bus_sel <= win;
      end else if (!HOLD_IDLE) begin
        bus_out <= '0;
        bus_sel <= '0;
      end
      bus_valid <= any;
      conflict  <= multi;
    end
  end

  // Saturating conflict counter; a synchronous clear overrides a simultaneous conflict
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      conflict_cnt <= '0;
    end else if (cnt_clear) begin
      conflict_cnt <= '0;
    end else if (multi && (conflict_cnt != CNT_MAX)) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_mux_pipe.sv
// tb/tb_bus_mux_pipe.sv - randomized model-checked bench for bus_mux_pipe
module tb_bus_mux_pipe;

  localparam int DW = 32;
  localparam int NS = 24;
  localparam int SW = 5;

  logic            clk = 1'b0;
  logic            clr = 1'b1;
  logic [DW-1:0]   src [NS];
  logic [NS*DW-1:0] src_data;
  logic [NS-1:0]   src_en = '0;
  logic            cnt_clear = 1'b0;

  logic [DW-1:0] a_bus, b_bus;
  logic          a_valid, b_valid;
  logic [SW-1:0] a_sel, b_sel;
  logic          a_conf, b_conf;
  logic [3:0]    a_cnt;
  logic [7:0]    b_cnt;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Pack the per-source array into the flat bus
  always_comb begin
    src_data = '0;
    for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = src[i];
  end

  bus_mux_pipe #(.DATA_W(DW), .NUM_SRC(NS), .SEL_W(SW), .HOLD_IDLE(1'b1), .CNT_W(4)) dut_a (
    .clk(clk), .clr(clr), .src_data(src_data), .src_en(src_en), .cnt_clear(cnt_clear),
    .bus_out(a_bus), .bus_valid(a_valid), .bus_sel(a_sel), .conflict(a_conf), .conflict_cnt(a_cnt));

  bus_mux_pipe #(.DATA_W(DW), .NUM_SRC(NS), .SEL_W(SW), .HOLD_IDLE(1'b0), .CNT_W(8)) dut_b (
    .clk(clk), .clr(clr), .src_data(src_data), .src_en(src_en), .cnt_clear(cnt_clear),
    .bus_out(b_bus), .bus_valid(b_valid), .bus_sel(b_sel), .conflict(b_conf), .conflict_cnt(b_cnt));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int first_set(input logic [NS-1:0] e);
    for (int i = 0; i < NS; i++) if (e[i]) return i;
    return -1;
  endfunction

  // Reference model: a = hold idle / 4-bit counter, b = zero idle / 8-bit counter
  logic [DW-1:0] ma_bus, mb_bus;
  int            ma_sel, mb_sel, ma_cnt, mb_cnt;
  logic          m_valid, m_conf;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      ma_bus <= '0; mb_bus <= '0; ma_sel <= 0; mb_sel <= 0;
      m_valid <= 1'b0; m_conf <= 1'b0; ma_cnt <= 0; mb_cnt <= 0;
    end else begin
      int w;
      w = first_set(src_en);
      if (w >= 0) begin
        ma_bus <= src[w]; mb_bus <= src[w]; ma_sel <= w; mb_sel <= w;
      end else begin
        mb_bus <= '0; mb_sel <= 0;
      end
      m_valid <= (w >= 0);
      m_conf  <= ($countones(src_en) >= 2);
      if (cnt_clear) begin
        ma_cnt <= 0; mb_cnt <= 0;
      end else if ($countones(src_en) >= 2) begin
        ma_cnt <= (ma_cnt + 1 > 15)  ? 15  : ma_cnt + 1;
        mb_cnt <= (mb_cnt + 1 > 255) ? 255 : mb_cnt + 1;
      end
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(posedge clk) begin
    #2;
    check("a_bus",   a_bus,   ma_bus);
    check("a_sel",   32'(a_sel), ma_sel);
    check("a_valid", 32'(a_valid), 32'(m_valid));
    check("a_conf",  32'(a_conf),  32'(m_conf));
    check("a_cnt",   32'(a_cnt),   ma_cnt);
    check("b_bus",   b_bus,   mb_bus);
    check("b_sel",   32'(b_sel), mb_sel);
    check("b_valid", 32'(b_valid), 32'(m_valid));
    check("b_conf",  32'(b_conf),  32'(m_conf));
    check("b_cnt",   32'(b_cnt),   mb_cnt);
  end

  task automatic edge_wait;
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < NS; i++) src[i] = $urandom;
    repeat (2) @(negedge clk);
    clr = 1'b0;

    // Asynchronous reset mid-cycle with R2 enabled
    @(negedge clk);
    src_en = 24'h000004; src[2] = 32'h2222_0002;
    edge_wait();
    check("pre_rst_bus", a_bus, 32'h2222_0002);
    @(negedge clk);
    #2 clr = 1'b1;
    #1;
    check("rst_bus",   a_bus, 0);
    check("rst_valid", 32'(a_valid), 0);
    check("rst_sel",   32'(a_sel), 0);
    check("rst_conf",  32'(a_conf), 0);
    check("rst_cnt",   32'(a_cnt), 0);
    @(negedge clk);
    clr = 1'b0;
    edge_wait();
    check("post_rst_bus",   a_bus, 32'h2222_0002);
    check("post_rst_sel",   32'(a_sel), 2);
    check("post_rst_valid", 32'(a_valid), 1);

    // Single source: PC
    @(negedge clk);
    src_en = 24'h100000; src[20] = 32'h0000_00A4; cnt_clear = 1'b1;
    edge_wait();
    check("pc_bus",   a_bus, 32'h0000_00A4);
    check("pc_sel",   32'(a_sel), 20);
    check("pc_valid", 32'(a_valid), 1);
    check("pc_conf",  32'(a_conf), 0);

    // Conflict R1 vs R5
    @(negedge clk);
    cnt_clear = 1'b0; src_en = 24'h000022; src[1] = 32'h11; src[5] = 32'h55;
    edge_wait();
    check("cf_bus",  b_bus, 32'h11);
    check("cf_sel",  32'(b_sel), 1);
    check("cf_conf", 32'(b_conf), 1);
    check("cf_cnt",  32'(b_cnt), 1);
    @(negedge clk);
    src_en = '0;
    edge_wait();
    check("cf_off_conf", 32'(a_conf), 0);
    check("cf_off_cnt",  32'(a_cnt), 1);

    // Idle behaviour after DEADBEEF on R3
    @(negedge clk);
    src_en = 24'h000008; src[3] = 32'hDEAD_BEEF;
    edge_wait();
    @(negedge clk);
    src_en = '0;
    for (int k = 0; k < 3; k++) begin
      edge_wait();
      check("hold_bus",   a_bus, 32'hDEAD_BEEF);
      check("hold_sel",   32'(a_sel), 3);
      check("hold_valid", 32'(a_valid), 0);
      check("zero_bus",   b_bus, 0);
      check("zero_sel",   32'(b_sel), 0);
    end

    // Saturation: counters at 1, then 20 conflict cycles
    @(negedge clk);
    src_en = 24'h000003;
    repeat (19) @(negedge clk);
    edge_wait();
    check("sat_a_cnt", 32'(a_cnt), 15);
    check("sat_b_cnt", 32'(b_cnt), 21);
    @(negedge clk);
    cnt_clear = 1'b1;
    edge_wait();
    check("clr_a_cnt", 32'(a_cnt), 0);
    check("clr_b_cnt", 32'(b_cnt), 0);
    @(negedge clk);
    cnt_clear = 1'b0;
    edge_wait();
    check("reclr_a_cnt", 32'(a_cnt), 1);

    // Streaming on R7
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      src_en = 24'h000080; src[7] = k;
      edge_wait();
      check("stream_bus", a_bus, k);
    end

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      clr = 1'b0;
      for (int i = 0; i < NS; i++) if ($urandom_range(0, 3) == 0) src[i] = $urandom;
      case ($urandom_range(0, 3))
        0: src_en = '0;
        1: src_en = NS'(1) << $urandom_range(0, NS-1);
        2: src_en = (NS'(1) << $urandom_range(0, NS-1)) | (NS'(1) << $urandom_range(0, NS-1));
        default: src_en = NS'($urandom & $urandom);
      endcase
      cnt_clear = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) begin
        #2 clr = 1'b1;
      end
    end
    @(negedge clk);
    clr = 1'b0; src_en = '0;
    edge_wait();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
